// File: rtl/gb_alu_pkg.sv
// Shared ALU package: flag bit positions, sub16_seq FSM states and request payload.
package gb_alu_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned FLAG_W = 4;

    localparam int unsigned FLAG_Z = 3;
    localparam int unsigned FLAG_N = 2;
    localparam int unsigned FLAG_H = 1;
    localparam int unsigned FLAG_C = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2
    } sub16_state_e;

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [FLAG_W-1:0] f;
    } sub16_req_t;

endpackage

// File: rtl/sub16_seq_if.sv
// Start/done handshake and operand/result bus between the CPU control FSM and sub16_seq.
interface sub16_seq_if;
    import gb_alu_pkg::*;

    logic              i_Start;
    logic [DATA_W-1:0] i_A;
    logic [DATA_W-1:0] i_B;
    logic [FLAG_W-1:0] i_F;
    logic              o_Busy;
    logic              o_Done;
    logic [DATA_W-1:0] o_Result;
    logic [FLAG_W-1:0] o_F;

    modport master (
        output i_Start, i_A, i_B, i_F,
        input  o_Busy, o_Done, o_Result, o_F
    );

    modport slave (
        input  i_Start, i_A, i_B, i_F,
        output o_Busy, o_Done, o_Result, o_F
    );

endinterface

// File: rtl/sub16_seq_subtractor8.sv
// Combinational 8-bit slice: A - B - borrow_in, with borrow out of bit 7 and half-borrow out of bit 3.
module subtractor8
    import gb_alu_pkg::*;
(
    input  logic [BYTE_W-1:0] i_A,
    input  logic [BYTE_W-1:0] i_B,
    input  logic              i_Borrow,
    output logic [BYTE_W-1:0] o_Diff,
    output logic              o_Borrow,
    output logic              o_Half_Borrow
);

    localparam int unsigned FULL_W = BYTE_W + 1;
    localparam int unsigned NIB_W  = 5;

    logic [FULL_W-1:0] w_full;
    logic [NIB_W-1:0]  w_nib;

    // Zero-extended subtraction: the extra top bit is set exactly when a borrow is needed.
    assign w_full = {1'b0, i_A} - {1'b0, i_B} - FULL_W'(i_Borrow);
    assign w_nib  = {1'b0, i_A[3:0]} - {1'b0, i_B[3:0]} - NIB_W'(i_Borrow);

    assign o_Diff        = w_full[BYTE_W-1:0];
    assign o_Borrow      = w_full[BYTE_W];
    assign o_Half_Borrow = w_nib[NIB_W-1];

endmodule

// File: rtl/sub16_seq.sv
// Byte-serial 16-bit subtractor (low byte then high byte) with SM83-style {Z,N,H,C} flags.
// Define SUB16_ZFLAG_EN to compute Z from the result; otherwise Z passes through from i_F.
module sub16_seq
    import gb_alu_pkg::*;
(
    input  logic        i_Clk,
    input  logic        i_Reset,
    sub16_seq_if.slave  bus
);

    sub16_state_e      r_state, w_state_nxt;
    sub16_req_t        r_req, w_req_nxt;
    logic [BYTE_W-1:0] r_lo, w_lo_nxt;
    logic              r_borrow, w_borrow_nxt;
    logic [DATA_W-1:0] r_result, w_result_nxt;
    logic [FLAG_W-1:0] r_flags, w_flags_nxt;
    logic              r_busy, w_busy_nxt;
    logic              r_done, w_done_nxt;

    logic [BYTE_W-1:0] w_slice_a;
    logic [BYTE_W-1:0] w_slice_b;
    logic              w_slice_bin;
    logic [BYTE_W-1:0] w_diff;
    logic              w_bout;
    logic              w_half;
    logic [DATA_W-1:0] w_full_result;
    logic [FLAG_W-1:0] w_new_flags;
    logic              w_unused_f;

    // Single slice shared by both bytes; the high byte consumes the stored low-byte borrow.
    assign w_slice_a   = (r_state == HIGH) ? r_req.a[DATA_W-1:BYTE_W] : r_req.a[BYTE_W-1:0];
    assign w_slice_b   = (r_state == HIGH) ? r_req.b[DATA_W-1:BYTE_W] : r_req.b[BYTE_W-1:0];
    assign w_slice_bin = (r_state == HIGH) && r_borrow;

    subtractor8 u_slice (
        .i_A           (w_slice_a),
        .i_B           (w_slice_b),
        .i_Borrow      (w_slice_bin),
        .o_Diff        (w_diff),
        .o_Borrow      (w_bout),
        .o_Half_Borrow (w_half)
    );

    assign w_full_result = {w_diff, r_lo};

    // H and C come from the high-byte pass only (bits 11 and 15 of the full word).
    always_comb begin
        w_new_flags         = '0;
        w_new_flags[FLAG_N] = 1'b1;
        w_new_flags[FLAG_H] = w_half;
        w_new_flags[FLAG_C] = w_bout;
`ifdef SUB16_ZFLAG_EN
        w_new_flags[FLAG_Z] = (w_full_result == '0);
`else
        w_new_flags[FLAG_Z] = r_req.f[FLAG_Z];
`endif
    end

`ifdef SUB16_ZFLAG_EN
    assign w_unused_f = ^r_req.f;
`else
    assign w_unused_f = ^{r_req.f[FLAG_N], r_req.f[FLAG_H], r_req.f[FLAG_C]};
`endif

    always_comb begin
        w_state_nxt  = r_state;
        w_req_nxt    = r_req;
        w_lo_nxt     = r_lo;
        w_borrow_nxt = r_borrow;
        w_result_nxt = r_result;
        w_flags_nxt  = r_flags;
        w_busy_nxt   = 1'b0;
        w_done_nxt   = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.i_Start) begin
                    w_state_nxt = LOW;
                    w_req_nxt   = '{a: bus.i_A, b: bus.i_B, f: bus.i_F};
                    w_busy_nxt  = 1'b1;
                end
            end
            LOW: begin
                w_state_nxt  = HIGH;
                w_lo_nxt     = w_diff;
                w_borrow_nxt = w_bout;
                w_busy_nxt   = 1'b1;
            end
            HIGH: begin
                w_state_nxt  = IDLE;
                w_result_nxt = w_full_result;
                w_flags_nxt  = w_new_flags;
                w_done_nxt   = 1'b1;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            r_state  <= IDLE;
            r_req    <= '0;
            r_lo     <= '0;
            r_borrow <= 1'b0;
            r_result <= '0;
            r_flags  <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_req    <= w_req_nxt;
            r_lo     <= w_lo_nxt;
            r_borrow <= w_borrow_nxt;
            r_result <= w_result_nxt;
            r_flags  <= w_flags_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
        end
    end

    assign bus.o_Busy   = r_busy;
    assign bus.o_Done   = r_done;
    assign bus.o_Result = r_result;
    assign bus.o_F      = r_flags;

endmodule

// File: tb/tb_sub16_seq.sv
// Self-checking bench for sub16_seq: directed cases plus randomized operations against a reference model.
module tb_sub16_seq;
    import gb_alu_pkg::*;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_mis;

    sub16_seq_if bus ();

    sub16_seq dut (
        .i_Clk   (clk),
        .i_Reset (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] model_res(input logic [15:0] a, input logic [15:0] b);
        int d;
        d = int'(a) - int'(b);
        if (d < 0) d = d + 65536;
        return 16'(d);
    endfunction

    function automatic logic [3:0] model_flags(input logic [15:0] a, input logic [15:0] b,
                                               input logic [3:0] f);
        logic z, h, c;
        h = int'(a % 16'h1000) < int'(b % 16'h1000);
        c = int'(a) < int'(b);
`ifdef SUB16_ZFLAG_EN
        z = (a == b);
        if (f[3]) z = (a == b);
`else
        z = f[3];
`endif
        return {z, 1'b1, h, c};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch one operation from an idle (or done) cycle and wait, bounded, for o_Done.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [3:0] f,
                          input bit scramble, output int lat, output bit overlap);
        bus.i_A     = a;
        bus.i_B     = b;
        bus.i_F     = f;
        bus.i_Start = 1'b1;
        tick();
        bus.i_Start = 1'b0;
        if (scramble) begin
            bus.i_A = 16'($urandom);
            bus.i_B = 16'($urandom);
            bus.i_F = 4'($urandom);
        end
        lat     = -1;
        overlap = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (bus.o_Busy && bus.o_Done) overlap = 1'b1;
            if (bus.o_Done) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst         = 1'b1;
        bus.i_Start = 1'b1;
        bus.i_A     = 16'h1234;
        bus.i_B     = 16'h0001;
        bus.i_F     = 4'hF;
        repeat (3) tick();
        n_cmp++; if (bus.o_Busy !== 1'b0) begin n_mis++; $display("FAIL reset_busy: got %b want 0", bus.o_Busy); end
        n_cmp++; if (bus.o_Done !== 1'b0) begin n_mis++; $display("FAIL reset_done: got %b want 0", bus.o_Done); end
        n_cmp++; if (bus.o_Result !== 16'h0000) begin n_mis++; $display("FAIL reset_result: got %h want 0000", bus.o_Result); end
        n_cmp++; if (bus.o_F !== 4'h0) begin n_mis++; $display("FAIL reset_flags: got %h want 0", bus.o_F); end
        bus.i_Start = 1'b0;
        rst         = 1'b0;
        tick();
        n_cmp++; if (bus.o_Busy !== 1'b0) begin n_mis++; $display("FAIL post_reset_busy: got %b want 0", bus.o_Busy); end
    endtask

    // Cycle-by-cycle handshake profile for one operation, then result hold while idle.
    task automatic test_latency();
        logic [3:0] exp_f;
        exp_f = 4'b0110;
        bus.i_A = 16'h1000; bus.i_B = 16'h0001; bus.i_F = 4'h0; bus.i_Start = 1'b1;
        tick();
        bus.i_Start = 1'b0;
        n_cmp++; if ({bus.o_Busy, bus.o_Done} !== 2'b10) begin n_mis++; $display("FAIL lat_c1: busy/done got %b want 10", {bus.o_Busy, bus.o_Done}); end
        tick();
        n_cmp++; if ({bus.o_Busy, bus.o_Done} !== 2'b10) begin n_mis++; $display("FAIL lat_c2: busy/done got %b want 10", {bus.o_Busy, bus.o_Done}); end
        tick();
        n_cmp++; if ({bus.o_Busy, bus.o_Done} !== 2'b01) begin n_mis++; $display("FAIL lat_c3: busy/done got %b want 01", {bus.o_Busy, bus.o_Done}); end
        n_cmp++; if (bus.o_Result !== 16'h0FFF) begin n_mis++; $display("FAIL lat_result: got %h want 0fff", bus.o_Result); end
        n_cmp++; if (bus.o_F !== exp_f) begin n_mis++; $display("FAIL lat_flags: got %b want %b", bus.o_F, exp_f); end
        repeat (3) tick();
        n_cmp++; if ({bus.o_Busy, bus.o_Done} !== 2'b00) begin n_mis++; $display("FAIL hold_handshake: busy/done got %b want 00", {bus.o_Busy, bus.o_Done}); end
        n_cmp++; if (bus.o_Result !== 16'h0FFF) begin n_mis++; $display("FAIL hold_result: got %h want 0fff", bus.o_Result); end
        n_cmp++; if (bus.o_F !== exp_f) begin n_mis++; $display("FAIL hold_flags: got %b want %b", bus.o_F, exp_f); end
    endtask

    task automatic test_directed();
        logic [15:0] ta [4];
        logic [15:0] tb [4];
        logic [3:0]  tf [4];
        logic [15:0] er [4];
        logic [3:0]  ef [4];
        int          lat;
        bit          ov;
        ta[0] = 16'h1000; tb[0] = 16'h0001; tf[0] = 4'h0; er[0] = 16'h0FFF; ef[0] = 4'b0110;
        ta[1] = 16'h0000; tb[1] = 16'h0001; tf[1] = 4'h0; er[1] = 16'hFFFF; ef[1] = 4'b0111;
        ta[2] = 16'h1234; tb[2] = 16'h1234; tf[2] = 4'h0; er[2] = 16'h0000;
        ta[3] = 16'h8000; tb[3] = 16'h0001; tf[3] = 4'h8; er[3] = 16'h7FFF;
`ifdef SUB16_ZFLAG_EN
        ef[2] = 4'b1100;
        ef[3] = 4'b0110;
`else
        ef[2] = 4'b0100;
        ef[3] = 4'b1110;
`endif
        for (int i = 0; i < 4; i++) begin
            run_op(ta[i], tb[i], tf[i], 1'b0, lat, ov);
            n_cmp++; if (lat !== 2) begin n_mis++; $display("FAIL dir%0d_latency: got %0d want 2", i + 1, lat); end
            n_cmp++; if (bus.o_Result !== er[i]) begin n_mis++; $display("FAIL dir%0d_result: got %h want %h", i + 1, bus.o_Result, er[i]); end
            n_cmp++; if (bus.o_F !== ef[i]) begin n_mis++; $display("FAIL dir%0d_flags: got %b want %b", i + 1, bus.o_F, ef[i]); end
            n_cmp++; if (ov !== 1'b0) begin n_mis++; $display("FAIL dir%0d_overlap: busy&done seen %b want 0", i + 1, ov); end
        end
    endtask

    // Start while busy is ignored; a start in the done cycle is accepted.
    task automatic test_back_to_back();
        int lat;
        int extra;
        bus.i_A = 16'h0005; bus.i_B = 16'h0003; bus.i_F = 4'h0; bus.i_Start = 1'b1;
        tick();
        bus.i_A = 16'hFFFF; bus.i_B = 16'h0000; bus.i_F = 4'hF;
        lat = -1;
        for (int k = 1; k <= 6; k++) begin
            if (k >= 2) bus.i_Start = 1'b0;
            tick();
            if (bus.o_Done) begin
                lat = k;
                break;
            end
        end
        n_cmp++; if (lat !== 2) begin n_mis++; $display("FAIL b2b_first_latency: got %0d want 2", lat); end
        n_cmp++; if (bus.o_Result !== 16'h0002) begin n_mis++; $display("FAIL b2b_first_result: got %h want 0002", bus.o_Result); end
        bus.i_A = 16'h00FF; bus.i_B = 16'h0F00; bus.i_F = 4'h0; bus.i_Start = 1'b1;
        tick();
        bus.i_Start = 1'b0;
        lat = -1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (bus.o_Done) begin
                lat = k;
                break;
            end
        end
        n_cmp++; if (lat !== 2) begin n_mis++; $display("FAIL b2b_second_latency: got %0d want 2", lat); end
        n_cmp++; if (bus.o_Result !== model_res(16'h00FF, 16'h0F00)) begin n_mis++; $display("FAIL b2b_second_result: got %h want %h", bus.o_Result, model_res(16'h00FF, 16'h0F00)); end
        n_cmp++; if (bus.o_F !== model_flags(16'h00FF, 16'h0F00, 4'h0)) begin n_mis++; $display("FAIL b2b_second_flags: got %b want %b", bus.o_F, model_flags(16'h00FF, 16'h0F00, 4'h0)); end
        extra = 0;
        repeat (4) begin
            tick();
            if (bus.o_Done) extra++;
        end
        n_cmp++; if (extra !== 0) begin n_mis++; $display("FAIL b2b_no_extra_done: got %0d pulses want 0", extra); end
    endtask

    task automatic test_reset_mid();
        int lat;
        int extra;
        bit ov;
        bus.i_A = 16'h0300; bus.i_B = 16'h0100; bus.i_F = 4'hF; bus.i_Start = 1'b1;
        tick();
        bus.i_Start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++; if (bus.o_Done !== 1'b0) begin n_mis++; $display("FAIL abort_done: got %b want 0", bus.o_Done); end
        n_cmp++; if (bus.o_Busy !== 1'b0) begin n_mis++; $display("FAIL abort_busy: got %b want 0", bus.o_Busy); end
        n_cmp++; if (bus.o_Result !== 16'h0000) begin n_mis++; $display("FAIL abort_result: got %h want 0000", bus.o_Result); end
        n_cmp++; if (bus.o_F !== 4'h0) begin n_mis++; $display("FAIL abort_flags: got %h want 0", bus.o_F); end
        extra = 0;
        repeat (3) begin
            tick();
            if (bus.o_Done || bus.o_Busy) extra++;
        end
        n_cmp++; if (extra !== 0) begin n_mis++; $display("FAIL abort_quiet: got %0d active cycles want 0", extra); end
        run_op(16'h0300, 16'h0100, 4'h0, 1'b0, lat, ov);
        n_cmp++; if (lat !== 2) begin n_mis++; $display("FAIL after_abort_latency: got %0d want 2", lat); end
        n_cmp++; if (bus.o_Result !== 16'h0200) begin n_mis++; $display("FAIL after_abort_result: got %h want 0200", bus.o_Result); end
        n_cmp++; if (bus.o_F !== 4'b0100) begin n_mis++; $display("FAIL after_abort_flags: got %b want 0100", bus.o_F); end
    endtask

    task automatic test_random();
        logic [15:0] a, b;
        logic [3:0]  f;
        int          lat;
        bit          ov;
        for (int i = 0; i < 60; i++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            f = 4'($urandom);
            if ((i % 7) == 0) b = a;
            if ((i % 11) == 3) b = a + 16'h0001;
            if ((i % 13) == 5) b = {a[15:12], 12'($urandom)};
            run_op(a, b, f, 1'b1, lat, ov);
            n_cmp++; if (lat !== 2) begin n_mis++; $display("FAIL rnd%0d_latency: got %0d want 2", i, lat); end
            n_cmp++; if (bus.o_Result !== model_res(a, b)) begin n_mis++; $display("FAIL rnd%0d_result: a=%h b=%h got %h want %h", i, a, b, bus.o_Result, model_res(a, b)); end
            n_cmp++; if (bus.o_F !== model_flags(a, b, f)) begin n_mis++; $display("FAIL rnd%0d_flags: a=%h b=%h f=%h got %b want %b", i, a, b, f, bus.o_F, model_flags(a, b, f)); end
            n_cmp++; if (ov !== 1'b0) begin n_mis++; $display("FAIL rnd%0d_overlap: busy&done seen %b want 0", i, ov); end
        end
    endtask

    initial begin
        clk         = 1'b0;
        rst         = 1'b1;
        n_cmp       = 0;
        n_mis       = 0;
        bus.i_Start = 1'b0;
        bus.i_A     = '0;
        bus.i_B     = '0;
        bus.i_F     = '0;
        test_reset();
        test_latency();
        test_directed();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
